// File: rtl/rf_pkg.sv
// Shared types for the register-file write path. This covers the bank encoding,
// the write-request record and the pending-scoreboard indexing.
package rf_pkg;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int SB_W    = 2 + ADDR_W;
    localparam int SB_SIZE = 1 << SB_W;

    typedef enum logic [1:0] {
        BANK_INT    = 2'b00,
        BANK_FP     = 2'b01,
        BANK_EXT_LO = 2'b10,
        BANK_EXT_HI = 2'b11
    } rf_bank_t;

    typedef struct packed {
        rf_bank_t            bank;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } rf_wreq_t;

    // Flat scoreboard position of a register: bank in the upper bits.
    function automatic logic [SB_W-1:0] sb_index(input logic [1:0] bank,
                                                 input logic [ADDR_W-1:0] addr);
        return {bank, addr};
    endfunction

endpackage

// File: rtl/rf_wreq_fifo.sv
// Small synchronous FIFO of write requests. The head is visible combinationally.
// The pointers carry one extra wrap bit so that full can be told apart from empty.
module rf_wreq_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  rf_wreq_t push_data,
    input  logic     pop,
    output rf_wreq_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    rf_wreq_t         mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    // A push into a full FIFO is accepted only when a pop frees a slot at the same edge.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_reg[PTR_W-1:0]];

    // Storage write. The contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
        end
    end

    // Pointer advance. Each pointer wraps naturally through its extra bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between writeback, which always wins, and
// buffered receive writes. It keeps a per-register pending scoreboard and a
// starvation counter that asks the core to stall when the receive queue is stuck.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wb_valid,
    input  logic [1:0]  wb_bank,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [1:0]  rx_bank,
    input  logic [4:0]  rx_addr,
    input  logic [31:0] rx_data,
    input  logic [1:0]  chk_bank,
    input  logic [4:0]  chk_addr,
    output logic        chk_pending,
    output logic        rf_we,
    output logic [1:0]  rf_bank,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic        core_stall,
    output logic        proto_err
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [SB_SIZE-1:0] pending_reg;
    logic [SB_SIZE-1:0] pending_next;
    logic [SB_W-1:0]    rx_idx;
    logic [SB_W-1:0]    chk_idx;
    logic [SB_W-1:0]    clr_idx;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    rf_wreq_t           fifo_head;
    rf_wreq_t           rx_req;
    rf_wreq_t           win_req;
    logic               win_valid;

    logic               rx_accept;
    logic               rx_is_r0;
    logic               pend_clear_en;

    logic               rf_we_reg;
    logic [1:0]         rf_bank_reg;
    logic [4:0]         rf_addr_reg;
    logic [31:0]        rf_data_reg;
    logic               rf_from_fifo_reg;
    logic [CNT_W-1:0]   starve_cnt_reg;
    logic [CNT_W-1:0]   starve_cnt_next;
    logic               core_stall_reg;
    logic               proto_err_reg;

    assign rx_idx    = sb_index(rx_bank, rx_addr);
    assign chk_idx   = sb_index(chk_bank, chk_addr);
    assign clr_idx   = sb_index(rf_bank_reg, rf_addr_reg);

    // Refuse a receive write while its register still has one in flight, so that at most one FIFO entry per register exists.
    assign rx_ready  = rstn & ~fifo_full & ~pending_reg[rx_idx];
    assign rx_accept = rx_valid & rx_ready;
    assign rx_is_r0  = (rx_bank == BANK_INT) && (rx_addr == 5'd0);
    // Int r0 is hardwired to zero, so an accepted write to it is simply dropped.
    assign fifo_push = rx_accept & ~rx_is_r0;
    assign fifo_pop  = ~wb_valid & ~fifo_empty;
    assign rx_req    = '{bank: rf_bank_t'(rx_bank), addr: rx_addr, data: rx_data};

    assign chk_pending   = rstn & pending_reg[chk_idx];
    // The register file commits on the edge where the FIFO-sourced strobe is visible.
    assign pend_clear_en = rf_we_reg & rf_from_fifo_reg;

    rf_wreq_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fifo_push),
        .push_data (rx_req),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Per-register pending bit. A set and a clear never target the same bit at the same edge.
    for (genvar gi = 0; gi < SB_SIZE; gi++) begin : g_pending
        assign pending_next[gi] = (fifo_push && (rx_idx == SB_W'(gi))) |
                                  (pending_reg[gi] & ~(pend_clear_en && (clr_idx == SB_W'(gi))));
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    // Fixed-priority winner selection: writeback first, then the FIFO head.
    always_comb begin
        win_valid = 1'b0;
        win_req   = '0;
        if (wb_valid) begin
            win_valid = 1'b1;
            win_req   = '{bank: rf_bank_t'(wb_bank), addr: wb_addr, data: wb_data};
        end else if (!fifo_empty) begin
            win_valid = 1'b1;
            win_req   = fifo_head;
        end
    end

    // Registered write port toward the register file.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_we_reg        <= 1'b0;
            rf_bank_reg      <= 2'b00;
            rf_addr_reg      <= 5'd0;
            rf_data_reg      <= 32'd0;
            rf_from_fifo_reg <= 1'b0;
        end else begin
            rf_we_reg        <= win_valid;
            rf_from_fifo_reg <= fifo_pop;
            if (win_valid) begin
                rf_bank_reg <= win_req.bank;
                rf_addr_reg <= win_req.addr;
                rf_data_reg <= win_req.data;
            end
        end
    end

    // Starvation count: it grows while a waiting head loses and saturates at the limit.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (fifo_empty || fifo_pop) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg < CNT_W'(STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
        end
    end

    // Stall and sticky protocol-error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt_reg <= '0;
            core_stall_reg <= 1'b0;
            proto_err_reg  <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            core_stall_reg <= (starve_cnt_next == CNT_W'(STARVE_LIMIT));
            proto_err_reg  <= proto_err_reg | (wb_valid & core_stall_reg);
        end
    end

    assign rf_we      = rf_we_reg;
    assign rf_bank    = rf_bank_reg;
    assign rf_addr    = rf_addr_reg;
    assign rf_data    = rf_data_reg;
    assign core_stall = core_stall_reg;
    assign proto_err  = proto_err_reg;

endmodule
